// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared encodings and helpers for the decode interlock
//   Holds the multdiv busy-FSM state encoding, the hard-wired zero register,
//   the default multiply/divide latencies and the source-register hit test.
package hazard_stall_unit_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DEF_MULT_CYCLES = 17;
  localparam int DEF_DIV_CYCLES  = 33;

  // True when the decode instruction reads register r. r0 never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] r,
                                   input logic [4:0] rs,
                                   input logic [4:0] rt,
                                   input logic       uses_rs,
                                   input logic       uses_rt);
    return (r != REG_ZERO) && ((uses_rs && (rs == r)) || (uses_rt && (rt == r)));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_md_latency_counter.sv
// rtl/hazard_stall_unit_md_latency_counter.sv - multdiv remaining-cycle down counter
//   clock, resetn   : pipeline clock, asynchronous active-low reset
//   load, load_value: start a new operation with the given remaining count
//   dec             : decrement while an operation is in flight
//   zero            : remaining count has reached zero
module md_latency_counter #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - decode-stage interlock: load-use, multdiv and branch-flush control
//   clock, resetn          : pipeline clock, asynchronous active-low reset
//   FD_*                   : source registers / class of the instruction in decode
//   DX_*                   : destination / class of the instruction in execute
//   branch_taken           : taken branch resolved in execute this cycle
//   stall_PC, stall_FD     : hold PC and FD latch
//   nop_DX, flush_FD       : bubble into DX / FD on the next edge
//   md_start/busy/done/rd  : multdiv handshake and destination tracking
//   stall_cycles           : saturating count of stalled cycles
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       FD_rs,
  input  logic [4:0]       FD_rt,
  input  logic             FD_usesRs,
  input  logic             FD_usesRt,
  input  logic             FD_isMultDiv,
  input  logic [4:0]       DX_rd,
  input  logic             DX_memToReg,
  input  logic             DX_isMultDiv,
  input  logic             DX_isDiv,
  input  logic             branch_taken,
  output logic             stall_PC,
  output logic             stall_FD,
  output logic             nop_DX,
  output logic             flush_FD,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [4:0]       md_rd,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES);

  // The start cycle and the done cycle are not counted, hence the -2.
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 2);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 2);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       count_zero;
  logic       ld_use;
  logic       md_raw;
  logic       md_struct;
  logic       stall;

  assign md_busy = (state == ST_BUSY);
  assign md_done = (state == ST_DONE);

  // Gated by resetn so that no multdiv term can assert while reset is held.
  assign md_start = resetn && DX_isMultDiv && (state != ST_BUSY);

  assign ld_use    = DX_memToReg && reg_hit(DX_rd, FD_rs, FD_rt, FD_usesRs, FD_usesRt);
  // DONE needs no stall: the result writes back this cycle and the register
  // file forwards write-to-read internally.
  assign md_raw    = (md_busy  && reg_hit(md_rd, FD_rs, FD_rt, FD_usesRs, FD_usesRt)) ||
                     (md_start && reg_hit(DX_rd, FD_rs, FD_rt, FD_usesRs, FD_usesRt));
  assign md_struct = resetn && FD_isMultDiv && (md_busy || DX_isMultDiv);
  assign stall     = ld_use || md_raw || md_struct;

  // A taken branch discards the decode instruction, so flushing replaces stalling.
  assign flush_FD = branch_taken;
  assign nop_DX   = branch_taken || stall;
  assign stall_PC = stall && !branch_taken;
  assign stall_FD = stall && !branch_taken;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: state_next = md_start ? ST_BUSY : ST_IDLE;
      ST_BUSY:          if (count_zero) state_next = ST_DONE;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      md_rd        <= REG_ZERO;
      stall_cycles <= '0;
    end else begin
      state <= state_next;
      if (md_start) begin
        md_rd <= DX_rd;
      end
      if (stall && !branch_taken && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

  md_latency_counter #(
    .W(CW)
  ) u_md_latency_counter (
    .clock     (clock),
    .resetn    (resetn),
    .load      (md_start),
    .load_value(DX_isDiv ? DIV_LOAD : MULT_LOAD),
    .dec       (md_busy),
    .zero      (count_zero)
  );

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Decode-stage interlock controller for the processor pipeline. It sits directly upstream of the bypass/forwarding block: it holds PC/FD and injects bubbles into DX so that everything reaching execute can be satisfied by forwarding. It resolves load-use hazards, multdiv latency and structural hazards through an internal busy FSM, and handles taken-branch flushes. It also keeps a saturating stall-cycle performance counter.

Parameters:
MULT_CYCLES, 17, execute cycles from md_start to result for a multiply (≥2)
DIV_CYCLES, 33, execute cycles from md_start to result for a divide (≥2)
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clock  in  1  single pipeline clock, rising edge
resetn  in  1  asynchronous, active-low reset
FD_rs  in  5  source A register of the instruction in decode
FD_rt  in  5  source B register of the instruction in decode
FD_usesRs  in  1  decode instruction reads FD_rs
FD_usesRt  in  1  decode instruction reads FD_rt
FD_isMultDiv  in  1  decode instruction is mul/div
DX_rd  in  5  destination of the instruction in execute
DX_memToReg  in  1  execute instruction is a load
DX_isMultDiv  in  1  execute instruction is mul/div
DX_isDiv  in  1  qualifies DX_isMultDiv: 1 = divide, 0 = multiply
branch_taken  in  1  taken branch/jump resolved in execute this cycle
stall_PC  out  1  hold PC
stall_FD  out  1  hold FD latch
nop_DX  out  1  load a bubble into DX next edge
flush_FD  out  1  load a bubble into FD next edge
md_start  out  1  one-cycle pulse to the multdiv unit
md_busy  out  1  multdiv operation in flight
md_done  out  1  one-cycle pulse: result writes back this cycle
md_rd  out  5  destination of the in-flight or completing multdiv
stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, count=0, md_rd=0, stall_cycles=0. md_busy=0 and md_done=0. md-derived stall terms are forced to 0. Release is synchronous to the next clock edge.
- FSM states: IDLE, BUSY, DONE.
  - IDLE/DONE → BUSY when md_start. Latch md_rd<=DX_rd. Load count<=(DX_isDiv?DIV_CYCLES:MULT_CYCLES)-2.
  - BUSY: count decrements each cycle. At count==0 go to DONE.
  - DONE → IDLE, unless md_start in the same cycle, in which case → BUSY.
- md_start = DX_isMultDiv && state!=BUSY.
- md_busy = (state==BUSY). md_done = (state==DONE), registered.
- Total latency: the md_done cycle is exactly N cycles after the md_start cycle.
- hit(r) = r!=0 && ((FD_usesRs && FD_rs==r) || (FD_usesRt && FD_rt==r)).
- Stall terms:
  - ld_use = DX_memToReg && hit(DX_rd)
  - md_raw = (md_busy && hit(md_rd)) || (md_start && hit(DX_rd))
  - md_struct = FD_isMultDiv && (md_busy || DX_isMultDiv)
  - stall = ld_use || md_raw || md_struct
- No stall is raised in DONE for md_rd. The register file is write-before-read.
- Outputs when branch_taken=0: stall_PC = stall_FD = nop_DX = stall; flush_FD=0.
- Outputs when branch_taken=1: flush wins. flush_FD=1 and nop_DX=1. stall_PC=stall_FD=0 (the wrong-path stalled instruction is discarded).
- An in-flight multdiv is older than the branch and continues unaffected.
- stall_cycles increments on each cycle with (stall && !branch_taken). It saturates at all-ones and never wraps.
- Reset mid-operation abandons the multdiv. No md_done is emitted.

Decomposition:
- Shared package: FSM state encoding (2-bit localparams IDLE/BUSY/DONE), REG_ZERO=5'd0, default latencies.
- One natural sub-module: md_latency_counter. It owns load/decrement/zero-detect of count and is parameterised by width ceil(log2(max(MULT,DIV))).

Test Plan:
- Load lw r5 in DX, add r6,r5,r1 in FD (usesRs) → stall_PC=stall_FD=nop_DX=1 for 1 cycle; same with FD_rs=r0 → no stall.
- mul r7 enters DX (MULT_CYCLES=17), FD reads r7:
  - md_start pulse, md_busy 16 cycles, md_done exactly 17 cycles after md_start, md_rd=7.
  - Stall every cycle from md_start up to the cycle before md_done.
- div r3 in flight, FD_isMultDiv=1 → decode stalls until DONE; back-to-back DONE→BUSY with second md_start in the DONE cycle, no IDLE gap.
- Load-use stall concurrent with branch_taken=1 → flush_FD=1, nop_DX=1, stall_PC=0, stall_cycles unchanged.
- Deassert resetn mid-BUSY at count=5 → md_busy=0 immediately, no md_done after release, md_rd=0.
- With CNT_W=4, hold stall for 20 cycles → stall_cycles saturates at 15.
